// File: rtl/irq_ctrl_pkg.sv
// Shared types and helpers for the round-robin interrupt controller.
package irq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        NOTIFY,
        SERVE
    } state_t;

    localparam logic [31:0] MCAUSE_INT = 32'h8000_0000;

    function automatic logic [31:0] mcause_enc(input logic [4:0] idx);
        return {1'b1, 26'b0, idx};
    endfunction

endpackage

// File: rtl/irq_prio_pick.sv
// Rotated priority encoder: picks the first eligible index at or above ptr,
// wrapping past N-1 back to 0. Tie ptr to 0 for plain lowest-index priority.
module irq_prio_pick #(
    parameter int N  = 32,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    localparam logic [IW:0] N_W = (IW + 1)'(N);

    logic [2*N-1:0] doubled;
    logic [N-1:0]   rotated;
    logic [IW:0]    offset;
    logic [IW:0]    sum;

    always_comb begin
        doubled = {eligible, eligible};
        rotated = doubled[ptr +: N];
        offset  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) offset = (IW + 1)'(i);
        end
        // Undo the rotation modulo N.
        sum = {1'b0, ptr} + offset;
        if (sum >= N_W) sum = sum - N_W;
        valid = |eligible;
        idx   = sum[IW-1:0];
    end

endmodule

// File: rtl/irq_ctrl_rr.sv
// Interrupt controller: per-source edge/level capture, pending tracking, fixed or
// round-robin arbitration, and a NOTIFY/SERVE handshake with the trap unit.
module irq_ctrl_rr
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC = 32,
    parameter int RR_EN = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_SRC-1:0] mie_i,
    input  logic [N_SRC-1:0] int_req_i,
    input  logic [N_SRC-1:0] edge_mode_i,
    input  logic             int_rst_i,
    output logic             int_o,
    output logic [31:0]      mcause_o,
    output logic [N_SRC-1:0] int_fin_o,
    output logic             busy_o
);

    localparam int IW = $clog2(N_SRC);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_SRC - 1);

    state_t           state_q, state_d;
    logic [N_SRC-1:0] req_q, req_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [IW-1:0]    win_idx_q, win_idx_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [31:0]      mcause_q, mcause_d;
    logic             int_q, int_d;
    logic             busy_q, busy_d;

    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] fin;
    logic             complete;
    logic [IW-1:0]    pick_ptr;
    logic             pick_valid;
    logic [IW-1:0]    pick_idx;

    irq_prio_pick #(
        .N  (N_SRC),
        .IW (IW)
    ) u_pick (
        .eligible (eligible),
        .ptr      (pick_ptr),
        .valid    (pick_valid),
        .idx      (pick_idx)
    );

    // A reset in the completion cycle aborts the interrupt without a fin pulse.
    always_comb begin
        rise     = int_req_i & ~req_q & edge_mode_i;
        eligible = mie_i & ((edge_mode_i & pend_q) | (~edge_mode_i & int_req_i));
        complete = (state_q != IDLE) && int_rst_i && !rst_i;
        fin      = '0;
        if (complete) fin[win_idx_q] = 1'b1;
        pick_ptr = (RR_EN != 0) ? ptr_q : '0;
    end

    always_comb begin
        req_d     = int_req_i;
        pend_d    = ((pend_q & ~fin) | rise) & edge_mode_i;
        state_d   = state_q;
        win_idx_d = win_idx_q;
        ptr_d     = ptr_q;
        mcause_d  = mcause_q;
        int_d     = 1'b0;
        busy_d    = busy_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d   = NOTIFY;
                    win_idx_d = pick_idx;
                    mcause_d  = mcause_enc(5'(pick_idx));
                    int_d     = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            NOTIFY, SERVE: begin
                if (complete) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    if (RR_EN != 0) ptr_d = (win_idx_q == LAST_IDX) ? '0 : win_idx_q + 1'b1;
                end else begin
                    state_d = SERVE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            req_q     <= '0;
            pend_q    <= '0;
            win_idx_q <= '0;
            ptr_q     <= '0;
            mcause_q  <= MCAUSE_INT;
            int_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            pend_q    <= pend_d;
            win_idx_q <= win_idx_d;
            ptr_q     <= ptr_d;
            mcause_q  <= mcause_d;
            int_q     <= int_d;
            busy_q    <= busy_d;
        end
    end

    assign int_o     = int_q;
    assign mcause_o  = mcause_q;
    assign int_fin_o = fin;
    assign busy_o    = busy_q;

endmodule

// File: doc/irq_ctrl_rr.md
# irq_ctrl_rr

Parametrised successor to the core's single-level interrupt controller. Arbitrates among `N_SRC` external interrupt sources, each selectable as level- or edge-triggered, using fixed or round-robin priority. Raises a one-cycle `int_o` request to the CSR/trap unit, holds `mcause_o` for the serviced source, and pulses a one-hot `int_fin_o` completion back to the source when the core signals return from trap (`int_rst_i`).

## Interface
- `N_SRC`, default 32: number of sources, legal range 2..32.
- `RR_EN`, default 1: 0 = fixed priority (lowest index wins); 1 = round-robin.
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  reset, synchronous to `clk_i` and active-high; resets all state on the next rising edge.
- `mie_i`  in  N_SRC  per-source enable mask.
- `int_req_i`  in  N_SRC  raw interrupt requests.
- `edge_mode_i`  in  N_SRC  per-source trigger mode: 1 = rising-edge latched, 0 = level.
- `int_rst_i`  in  1  completion pulse from the core on mret.
- `int_o`  out  1  one-cycle interrupt request to the core.
- `mcause_o`  out  32  `{1'b1, 26'b0, idx[4:0]}`, where idx is the zero-extended index of the granted source.
- `int_fin_o`  out  N_SRC  one-hot completion pulse to the granted source.
- `busy_o`  out  1  high while an interrupt is outstanding (state not IDLE).

## Operation
- Edge detect:
  - `req_q` is a registered copy of `int_req_i`.
  - A rising edge is `int_req_i & ~req_q & edge_mode_i`.
  - Reset value of `req_q` is 0, so an input held high when reset releases counts as an edge.
- Pending (`pend`, N_SRC bits):
  - Set on a detected edge. Cleared by `int_fin_o` for that bit.
  - If set and clear occur in the same cycle, set wins.
  - Bits whose `edge_mode_i` is 0 are forced to 0.
  - Masking via `mie_i` does not clear `pend`.
- Eligible vector: `mie_i & (edge_mode_i ? pend : int_req_i)`, evaluated per bit.
- Priority pick:
  - Fixed mode: lowest eligible index wins.
  - RR mode: first eligible index at or above `ptr`, searching upward and wrapping past N_SRC-1 to 0.
- FSM states:
  - IDLE: if any source is eligible, latch the winner into `win_idx` and go to NOTIFY. Otherwise stay in IDLE.
  - NOTIFY: `int_o`=1 for exactly this cycle. If `int_rst_i`=1, complete and go to IDLE; otherwise go to SERVE.
  - SERVE: wait for `int_rst_i`. On `int_rst_i`=1, complete and go to IDLE.
- Complete:
  - `int_fin_o` = onehot(`win_idx`), combinational in the completion cycle.
  - The corresponding `pend` bit clears.
  - RR mode: `ptr` ← (`win_idx`+1) mod N_SRC. Fixed mode: `ptr` is unused and stays 0.
- `int_rst_i` in IDLE is ignored: `int_fin_o` stays 0 and no state changes.
- A level source deasserting while the FSM is in NOTIFY or SERVE does not cancel the interrupt; completion still occurs with the same cause.
- `mcause_o` is registered. It updates on the IDLE→NOTIFY transition and holds its value until the next grant.

## Timing
- Reset values:
  - State IDLE; `int_o`=0; `int_fin_o`=0; `busy_o`=0.
  - `mcause_o`=0x8000_0000; `pend`=0; `req_q`=0; `ptr`=0.
- Level latency: a request sampled high at edge k produces `int_o` high in the cycle after edge k (1 cycle).
- Edge latency: a rise sampled at edge k sets `pend` at edge k; `int_o` is high after edge k+1 (2 cycles).
- `mcause_o` is valid in the same cycle as `int_o` and stays stable through completion.
- Back-to-back: after completion at edge m, the FSM is in IDLE for the cycle after m. The next `int_o` is high no earlier than after edge m+1, giving a minimum of 1 idle cycle between grants.
- `rst_i` asserted mid-service returns all state to the reset values on the next edge. No `int_fin_o` is issued for the aborted interrupt.

## Structure
- Package `irq_ctrl_pkg`:
  - `state_t` enum {IDLE, NOTIFY, SERVE}.
  - `MCAUSE_INT` = 32'h8000_0000.
  - Function `mcause_enc(idx)`.
- Sub-module `irq_prio_pick #(N)`:
  - Inputs: `eligible` vector and `ptr`.
  - Outputs: `valid` and `idx`.
  - Implemented as a rotated priority encoder; fixed mode ties `ptr` to 0.
- Top level holds the edge-detect, pend, FSM, `ptr` and output registers.

## Test plan
- Fixed mode, all sources level, `mie_i`=all-ones: raise `int_req_i`=0x0000_0028 → `int_o` pulse with `mcause_o`=0x8000_0003. Then `int_rst_i` → `int_fin_o`=0x8. Next grant `mcause_o`=0x8000_0003 again while bit 3 is still held high, since fixed mode always picks the lowest index.
- RR mode, sources 1, 4 and 9 held high as level: three consecutive services give idx 1, 4, 9, then wrap to 1. `int_fin_o` is 0x2, 0x10, 0x200, 0x2 in turn.
- Edge mode on source 5: single-cycle pulse on `int_req_i[5]` → `int_o` 2 cycles after the rise, `mcause_o`=0x8000_0005. Hold `mie_i[5]`=0 for 10 cycles: `pend[5]` persists. Enabling `mie_i[5]` then produces `int_o` in the next cycle.
- Second edge on source 5 arriving in the same cycle as its `int_fin_o` → `pend[5]` stays set, and a second `int_o` follows with the same cause.
- `int_rst_i` asserted during IDLE → no `int_fin_o`, `busy_o` stays 0. `int_rst_i` asserted in the NOTIFY cycle → `int_fin_o` in that cycle, `busy_o` drops the next cycle.
- `rst_i` asserted while in SERVE for source 7 → `int_o`=0, `mcause_o`=0x8000_0000, `pend`=0 after the edge; `int_fin_o` never pulses for source 7.
